// File: rtl/sequenciador_entrada.sv
// Two-phase operator input sequencer: assembles a 32-bit word from two 16-bit switch
// samples committed by ch0 edges. Optional ch0 debounce enabled by SEQUENCIADOR_DEBOUNCE_EN.
module sequenciador_entrada #(
    parameter int unsigned DEBOUNCE_CICLOS = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] chaves,
    input  logic        ch0,
    input  logic        controle,
    output logic [31:0] dado,
    output logic        pronto,
    output logic        sup,
    output logic        inf
);

    localparam int unsigned MEIA_W = 16;
    localparam int unsigned DADO_W = 32;

    typedef enum logic [2:0] {
        OCIOSO,
        ESPERA_SUP,
        ESPERA_INF,
        ENTREGA,
        LIBERA
    } estado_t;

    if (DEBOUNCE_CICLOS < 1 || DEBOUNCE_CICLOS > 65535) begin : g_param_invalido
        $error("DEBOUNCE_CICLOS out of range 1..65535");
    end

    estado_t             estado_q, estado_d;
    logic [MEIA_W-1:0]   parte_sup_q, parte_sup_d;
    logic [DADO_W-1:0]   dado_q, dado_d;
    logic                pronto_q, pronto_d;
    logic                sup_q, sup_d;
    logic                inf_q, inf_d;
    logic                sinc1_q, ch0_s_q;
    logic                ch0_f_q, ch0_f_d;
    logic                ch0_f_ant_q;
    logic                sobe, desce;

`ifdef SEQUENCIADOR_DEBOUNCE_EN
    localparam logic [MEIA_W-1:0] LIMITE = MEIA_W'(DEBOUNCE_CICLOS);
    logic [MEIA_W-1:0] cont_q, cont_d;

    // Accept a new level only after LIMITE consecutive disagreeing cycles
    always_comb begin
        ch0_f_d = ch0_f_q;
        cont_d  = '0;
        if (ch0_s_q != ch0_f_q) begin
            if (cont_q + MEIA_W'(1) == LIMITE) begin
                ch0_f_d = ch0_s_q;
            end else begin
                cont_d = cont_q + MEIA_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cont_q <= '0;
        end else begin
            cont_q <= cont_d;
        end
    end
`else
    always_comb begin
        ch0_f_d = ch0_s_q;
    end
`endif

    assign sobe  = ch0_f_q & ~ch0_f_ant_q;
    assign desce = ~ch0_f_q & ch0_f_ant_q;

    // Next-state; an aborted request takes priority over any edge in the same cycle
    always_comb begin
        estado_d    = estado_q;
        parte_sup_d = parte_sup_q;
        dado_d      = dado_q;
        case (estado_q)
            OCIOSO: begin
                if (controle) estado_d = ESPERA_SUP;
            end
            ESPERA_SUP: begin
                if (!controle) begin
                    estado_d    = OCIOSO;
                    parte_sup_d = '0;
                end else if (sobe) begin
                    parte_sup_d = chaves;
                    estado_d    = ESPERA_INF;
                end
            end
            ESPERA_INF: begin
                if (!controle) begin
                    estado_d    = OCIOSO;
                    parte_sup_d = '0;
                end else if (desce) begin
                    dado_d   = {parte_sup_q, chaves};
                    estado_d = ENTREGA;
                end
            end
            ENTREGA: begin
                estado_d = LIBERA;
            end
            LIBERA: begin
                if (!controle) estado_d = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
        pronto_d = (estado_d == ENTREGA);
        sup_d    = (estado_d == ESPERA_SUP);
        inf_d    = (estado_d == ESPERA_INF);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q    <= OCIOSO;
            parte_sup_q <= '0;
            dado_q      <= '0;
            pronto_q    <= 1'b0;
            sup_q       <= 1'b0;
            inf_q       <= 1'b0;
            sinc1_q     <= 1'b0;
            ch0_s_q     <= 1'b0;
            ch0_f_q     <= 1'b0;
            ch0_f_ant_q <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            parte_sup_q <= parte_sup_d;
            dado_q      <= dado_d;
            pronto_q    <= pronto_d;
            sup_q       <= sup_d;
            inf_q       <= inf_d;
            sinc1_q     <= ch0;
            ch0_s_q     <= sinc1_q;
            ch0_f_q     <= ch0_f_d;
            ch0_f_ant_q <= ch0_f_q;
        end
    end

    assign dado   = dado_q;
    assign pronto = pronto_q;
    assign sup    = sup_q;
    assign inf    = inf_q;

endmodule

// File: tb/tb_sequenciador_entrada.sv
// Directed self-checking bench for sequenciador_entrada (DEBOUNCE_CICLOS=4);
// expectations follow SEQUENCIADOR_DEBOUNCE_EN when defined.
module tb_sequenciador_entrada;

`ifdef SEQUENCIADOR_DEBOUNCE_EN
    localparam int FILT = 4;
`else
    localparam int FILT = 1;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] chaves;
    logic        ch0;
    logic        controle;
    logic [31:0] dado;
    logic        pronto;
    logic        sup;
    logic        inf;

    int total = 0;
    int bad   = 0;

    sequenciador_entrada #(.DEBOUNCE_CICLOS(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .chaves   (chaves),
        .ch0      (ch0),
        .controle (controle),
        .dado     (dado),
        .pronto   (pronto),
        .sup      (sup),
        .inf      (inf)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; controle = 1'b0; ch0 = 1'b0; chaves = 16'h0000;
        tick(3);
        total++;
        if ({dado, pronto, sup, inf} !== 35'h0) begin
            bad++;
            $display("FAIL reset_state: got dado=%h pronto=%b sup=%b inf=%b, want all 0", dado, pronto, sup, inf);
        end
        reset = 1'b1;
        tick(2);
        total++;
        if ({pronto, sup, inf} !== 3'b000) begin
            bad++;
            $display("FAIL idle_after_reset: got pronto/sup/inf=%b%b%b, want 000", pronto, sup, inf);
        end
    endtask

    task automatic test_normal;
        int n;
        controle = 1'b1;
        tick(1);
        total++;
        if ({sup, inf} !== 2'b10) begin
            bad++;
            $display("FAIL normal_sup: got sup/inf=%b%b, want 10", sup, inf);
        end
        chaves = 16'hABCD; ch0 = 1'b1;
        tick(2 + FILT);
        total++;
        if ({sup, inf} !== 2'b10) begin
            bad++;
            $display("FAIL normal_rise_early: got sup/inf=%b%b, want 10", sup, inf);
        end
        tick(1);
        total++;
        if ({sup, inf} !== 2'b01) begin
            bad++;
            $display("FAIL normal_inf: got sup/inf=%b%b, want 01", sup, inf);
        end
        chaves = 16'h1234; ch0 = 1'b0;
        n = 0;
        while (n < 30 && pronto !== 1'b1) begin
            tick(1);
            n++;
        end
        total++;
        if (n !== 3 + FILT) begin
            bad++;
            $display("FAIL normal_latency: got %0d cycles, want %0d", n, 3 + FILT);
        end
        total++;
        if (dado !== 32'hABCD1234 || {sup, inf} !== 2'b00) begin
            bad++;
            $display("FAIL normal_word: got dado=%h sup/inf=%b%b, want ABCD1234 00", dado, sup, inf);
        end
        tick(1);
        total++;
        if ({pronto, sup, inf} !== 3'b000) begin
            bad++;
            $display("FAIL normal_pulse: got pronto/sup/inf=%b%b%b, want 000", pronto, sup, inf);
        end
    endtask

    task automatic test_single_word;
        int pulsos;
        pulsos = 0;
        for (int t = 0; t < 4; t++) begin
            ch0 = ~ch0;
            for (int c = 0; c < 15; c++) begin
                tick(1);
                if (pronto === 1'b1) pulsos++;
            end
        end
        total++;
        if (pulsos !== 0 || {sup, inf} !== 2'b00) begin
            bad++;
            $display("FAIL single_word: got %0d extra pulses sup/inf=%b%b, want 0 00", pulsos, sup, inf);
        end
        controle = 1'b0;
        tick(2);
        controle = 1'b1;
        tick(1);
        total++;
        if ({sup, inf} !== 2'b10) begin
            bad++;
            $display("FAIL new_request: got sup/inf=%b%b, want 10", sup, inf);
        end
    endtask

    task automatic test_bounce;
        chaves = 16'hFFFF;
`ifdef SEQUENCIADOR_DEBOUNCE_EN
        ch0 = 1'b1;
        tick(3);
        ch0 = 1'b0;
        tick(12);
        total++;
        if ({sup, inf} !== 2'b10) begin
            bad++;
            $display("FAIL bounce_glitch: got sup/inf=%b%b, want 10", sup, inf);
        end
`endif
        ch0 = 1'b1;
        tick(2 + FILT);
        total++;
        if ({sup, inf} !== 2'b10) begin
            bad++;
            $display("FAIL bounce_early: got sup/inf=%b%b, want 10", sup, inf);
        end
        tick(1);
        total++;
        if ({sup, inf} !== 2'b01) begin
            bad++;
            $display("FAIL bounce_capture: got sup/inf=%b%b, want 01", sup, inf);
        end
    endtask

    task automatic test_abort;
        int pulsos;
        ch0 = 1'b0;
        tick(2 + FILT);
        controle = 1'b0;
        tick(1);
        total++;
        if ({pronto, sup, inf} !== 3'b000 || dado !== 32'hABCD1234) begin
            bad++;
            $display("FAIL abort: got pronto/sup/inf=%b%b%b dado=%h, want 000 ABCD1234", pronto, sup, inf, dado);
        end
        pulsos = 0;
        for (int c = 0; c < 8; c++) begin
            tick(1);
            if (pronto === 1'b1) pulsos++;
        end
        total++;
        if (pulsos !== 0 || dado !== 32'hABCD1234) begin
            bad++;
            $display("FAIL abort_quiet: got %0d pulses dado=%h, want 0 ABCD1234", pulsos, dado);
        end
    endtask

    task automatic test_reset_mid;
        int pulsos;
        controle = 1'b1;
        tick(1);
        chaves = 16'h5555; ch0 = 1'b1;
        tick(3 + FILT);
        total++;
        if ({sup, inf} !== 2'b01) begin
            bad++;
            $display("FAIL midreset_setup: got sup/inf=%b%b, want 01", sup, inf);
        end
        reset = 1'b0; ch0 = 1'b0;
        tick(1);
        reset = 1'b1;
        total++;
        if ({dado, pronto, sup, inf} !== 35'h0) begin
            bad++;
            $display("FAIL midreset_clear: got dado=%h pronto/sup/inf=%b%b%b, want 0 000", dado, pronto, sup, inf);
        end
        tick(1);
        total++;
        if ({sup, inf} !== 2'b10) begin
            bad++;
            $display("FAIL midreset_restart: got sup/inf=%b%b, want 10", sup, inf);
        end
        pulsos = 0;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            if (pronto === 1'b1) pulsos++;
        end
        total++;
        if (pulsos !== 0 || sup !== 1'b1 || dado !== 32'h0) begin
            bad++;
            $display("FAIL midreset_quiet: got %0d pulses sup=%b dado=%h, want 0 1 0", pulsos, sup, dado);
        end
        controle = 1'b0;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_normal();
        test_single_word();
        test_bounce();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
